// File: rtl/aes_start_gen.sv
// Start/done handshake initiator for the AES core: drives a level start, measures
// cycles until done rises and returns the latency via valid/ready. Optional timeout: AES_START_GEN_TIMEOUT_EN.
module aes_start_gen #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             req_ready_o,
  output logic             start_o,
  input  logic             done_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [CNT_W-1:0] latency_o,
  output logic             timeout_o,
  input  logic [CNT_W-1:0] timeout_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t           state;
  logic             done_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] latency_q;
  logic             timeout_q;
  logic             resp_valid_q;
  logic             rise;
  logic             tmo_fire;

  assign rise = done_i & ~done_q;

`ifdef AES_START_GEN_TIMEOUT_EN
  assign tmo_fire = (timeout_i != '0) && (cnt == timeout_i - CNT_W'(1)) && !rise;
`else
  logic timeout_unused;
  assign timeout_unused = ^timeout_i;
  assign tmo_fire       = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      done_q       <= 1'b0;
      cnt          <= '0;
      latency_q    <= '0;
      timeout_q    <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      done_q <= done_i;
      case (state)
        IDLE: begin
          if (req_i && !done_i) begin
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          // rise has priority over a timeout landing in the same cycle
          if (rise) begin
            latency_q    <= cnt;
            timeout_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end else if (tmo_fire) begin
            latency_q    <= cnt;
            timeout_q    <= 1'b1;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state        <= DRAIN;
          end
        end
        DRAIN: begin
          if (!done_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gating keeps ready low while rst_i is held, even with the state already IDLE.
  assign req_ready_o  = (state == IDLE) & ~done_i & ~rst_i;
  assign start_o      = (state == BUSY);
  assign busy_o       = (state != IDLE);
  assign resp_valid_o = resp_valid_q;
  assign latency_o    = latency_q;
  assign timeout_o    = timeout_q;

endmodule
